// File: rtl/div_share_arbiter_pkg.sv
// rtl/div_share_arbiter_pkg.sv - shared states, defaults and round-robin picker
package div_share_pkg;

  localparam int DEF_N = 4;
  localparam int DEF_W = 32;
  localparam int MAX_N = 8;

  // Quotient reported for a divide-by-zero, sliced to W by the user
  localparam logic [63:0] ALL_ONES = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STORE = 2'd2
  } state_t;

  // First requester after 'last' in cyclic order among n channels, one-hot; zero if none
  function automatic logic [MAX_N-1:0] rr_pick(input logic [MAX_N-1:0] req,
                                               input logic [2:0]       last,
                                               input int               n);
    logic [MAX_N-1:0] pick;
    logic             found;
    logic [2:0]       idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_N; k++) begin
      idx = 3'((int'(last) + k) % n);
      if (k <= n && !found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/div_share_arbiter_if.sv
// rtl/div_share_arbiter_if.sv - requester-side bundle of the shared divider
interface div_share_arbiter_if
  import div_share_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
);

  logic [N-1:0]   REQ;
  logic [N*W-1:0] NUM;
  logic [N*W-1:0] DEN;
  logic [N-1:0]   ACK;
  logic [N-1:0]   VALID;
  logic [N*W-1:0] QUO;
  logic [N*W-1:0] REM;
  logic [N-1:0]   DIV0;
  logic           BUSY;

  modport master (output REQ, NUM, DEN,
                  input  ACK, VALID, QUO, REM, DIV0, BUSY);

  modport slave  (input  REQ, NUM, DEN,
                  output ACK, VALID, QUO, REM, DIV0, BUSY);

endinterface

// File: rtl/div_share_arbiter_seq_core.sv
// rtl/div_share_arbiter_seq_core.sv - start/done serial restoring divider, W cycles
module div_seq_core
  import div_share_pkg::*;
#(
  parameter int W = DEF_W
)
(
  input  logic         CLK,
  input  logic         RSTB,
  input  logic         start,
  input  logic [W-1:0] num,
  input  logic [W-1:0] den,
  output logic         done,
  output logic [W-1:0] quo,
  output logic [W-1:0] rem
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]  q_r;
  logic [W-1:0]  pr_r;
  logic [CW-1:0] cnt_r;
  logic          run_r;
  logic [W:0]    shifted;
  logic          ge;
  logic [W-1:0]  diff;

  // Trial subtract: the W+1-bit shifted remainder keeps DEN up to 2^W-1 exact
  always_comb begin
    shifted = {pr_r, q_r[W-1]};
    ge      = shifted >= {1'b0, den};
    diff    = shifted[W-1:0] - den;
  end

  // Load on start, then retire one quotient bit per cycle, MSB first
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      q_r   <= '0;
      pr_r  <= '0;
      cnt_r <= '0;
      run_r <= 1'b0;
    end else if (start) begin
      q_r   <= num;
      pr_r  <= '0;
      cnt_r <= CW'(W - 1);
      run_r <= 1'b1;
    end else if (run_r) begin
      pr_r <= ge ? diff : shifted[W-1:0];
      q_r  <= {q_r[W-2:0], ge};
      if (cnt_r == '0) run_r <= 1'b0;
      else             cnt_r <= cnt_r - 1'b1;
    end
  end

  assign done = run_r && (cnt_r == '0);
  assign quo  = q_r;
  assign rem  = pr_r;

endmodule

// File: rtl/div_share_arbiter.sv
// rtl/div_share_arbiter.sv - round-robin sharing of one serial divider among N requesters
module div_share_arbiter
  import div_share_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
)
(
  input  logic             CLK,
  input  logic             RSTB,
  div_share_arbiter_if.slave bus
);

  state_t           state;
  logic [2:0]       last;
  logic [2:0]       gidx;
  logic [2:0]       widx;
  logic [MAX_N-1:0] req8;
  logic [MAX_N-1:0] pick8;
  logic             any_req;
  logic [W-1:0]     win_num;
  logic [W-1:0]     win_den;
  logic [W-1:0]     num_q;
  logic [W-1:0]     den_q;
  logic [N-1:0]     gmask;
  logic [N-1:0]     ack_r;
  logic [N-1:0]     valid_r;
  logic [N-1:0]     div0_r;
  logic [N*W-1:0]   quo_r;
  logic [N*W-1:0]   rem_r;
  logic             busy_r;
  logic             core_start;
  logic             core_done;
  logic [W-1:0]     core_quo;
  logic [W-1:0]     core_rem;

  // Round-robin winner among live requests and that channel's operands
  always_comb begin
    req8        = '0;
    req8[N-1:0] = bus.REQ;
    pick8       = rr_pick(req8, last, N);
    widx        = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (pick8[i]) widx = 3'(i);
    end
    any_req = |bus.REQ;
    win_num = bus.NUM[widx*W +: W];
    win_den = bus.DEN[widx*W +: W];
  end

  // Divide-by-zero never starts the core, so it stays idle and BUSY stays low
  assign core_start = (state == IDLE) && any_req && (win_den != '0);
  assign gmask      = N'(1) << gidx;

  div_seq_core #(.W(W)) u_core (
    .CLK   (CLK),
    .RSTB  (RSTB),
    .start (core_start),
    .num   (win_num),
    .den   (den_q),
    .done  (core_done),
    .quo   (core_quo),
    .rem   (core_rem)
  );

  // Grant, capture, result storage and handshake pulses
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state   <= IDLE;
      last    <= 3'(N - 1);
      gidx    <= '0;
      num_q   <= '0;
      den_q   <= '0;
      ack_r   <= '0;
      valid_r <= '0;
      div0_r  <= '0;
      quo_r   <= '0;
      rem_r   <= '0;
      busy_r  <= 1'b0;
    end else begin
      ack_r   <= '0;
      valid_r <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            gidx  <= widx;
            num_q <= win_num;
            den_q <= win_den;
            ack_r <= N'(1) << widx;
            if (win_den == '0) begin
              state <= STORE;
            end else begin
              state  <= RUN;
              busy_r <= 1'b1;
            end
          end
        end
        RUN: begin
          if (core_done) state <= STORE;
        end
        STORE: begin
          if (den_q == '0) begin
            quo_r[gidx*W +: W] <= ALL_ONES[W-1:0];
            rem_r[gidx*W +: W] <= num_q;
            div0_r             <= div0_r | gmask;
          end else begin
            quo_r[gidx*W +: W] <= core_quo;
            rem_r[gidx*W +: W] <= core_rem;
            div0_r             <= div0_r & ~gmask;
          end
          valid_r <= gmask;
          last    <= gidx;
          busy_r  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ACK   = ack_r;
  assign bus.VALID = valid_r;
  assign bus.QUO   = quo_r;
  assign bus.REM   = rem_r;
  assign bus.DIV0  = div0_r;
  assign bus.BUSY  = busy_r;

endmodule

// File: tb/tb_div_share_arbiter.sv
// tb/tb_div_share_arbiter.sv - randomized self-checking bench for div_share_arbiter
module tb_div_share_arbiter;
  import div_share_pkg::*;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic CLK  = 1'b0;
  logic RSTB = 1'b0;
  int   cyc  = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  div_share_arbiter_if #(.N(N), .W(W)) bus ();

  div_share_arbiter #(.N(N), .W(W)) dut (
    .CLK  (CLK),
    .RSTB (RSTB),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // reference state: results per channel, pending expectations, last winner
  logic [W-1:0] m_quo [N];
  logic [W-1:0] m_rem [N];
  logic         m_div0[N];
  logic         pend  [N];
  logic [W-1:0] p_quo [N];
  logic [W-1:0] p_rem [N];
  logic         p_div0[N];
  int           ack_cyc[N];
  int           m_last;
  int           q_grant[$];
  int           q_vcyc[$];
  logic [W-1:0] b_num[N];
  logic [W-1:0] b_den[N];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic bit any_pend();
    bit r = 0;
    for (int i = 0; i < N; i++) r |= pend[i];
    return r;
  endfunction

  // One cycle: observe at the falling edge, then requesters drop REQ on ACK
  task automatic step();
    @(negedge CLK);
    if (bus.ACK != '0) begin
      check("ack_onehot", 128'($onehot(bus.ACK)), 1);
      for (int i = 0; i < N; i++) if (bus.ACK[i]) begin
        ack_cyc[i] = cyc;
        q_grant.push_back(i);
      end
    end
    if (bus.VALID != '0) begin
      check("valid_onehot", 128'($onehot(bus.VALID)), 1);
      for (int i = 0; i < N; i++) if (bus.VALID[i]) begin
        check("valid_expected", 128'(pend[i]), 1);
        check("valid_lat", 128'(cyc - ack_cyc[i]), p_div0[i] ? 1 : W + 1);
        m_quo[i]  = p_quo[i];
        m_rem[i]  = p_rem[i];
        m_div0[i] = p_div0[i];
        pend[i]   = 1'b0;
        q_vcyc.push_back(cyc);
      end
    end
    for (int i = 0; i < N; i++)
      check("hold", {bus.QUO[i*W +: W], bus.REM[i*W +: W], bus.DIV0[i]},
                    {m_quo[i], m_rem[i], m_div0[i]});
    for (int i = 0; i < N; i++) if (bus.ACK[i]) begin
      bus.REQ[i]         = 1'b0;
      bus.NUM[i*W +: W]  = $urandom;
      bus.DEN[i*W +: W]  = $urandom;
    end
  endtask

  task automatic post(input int ch);
    bus.NUM[ch*W +: W] = b_num[ch];
    bus.DEN[ch*W +: W] = b_den[ch];
    bus.REQ[ch]        = 1'b1;
    pend[ch]           = 1'b1;
    if (b_den[ch] == '0) begin
      p_quo[ch]  = '1;
      p_rem[ch]  = b_num[ch];
      p_div0[ch] = 1'b1;
    end else begin
      p_quo[ch]  = b_num[ch] / b_den[ch];
      p_rem[ch]  = b_num[ch] % b_den[ch];
      p_div0[ch] = 1'b0;
    end
  endtask

  // Raise all channels in mask at once (DUT idle) and check the full service
  task automatic batch(input logic [N-1:0] mask);
    int exp_order[$];
    int start;
    int k;
    bit busy_seen;
    bit all_norm;
    bit all_div0;
    q_grant.delete();
    q_vcyc.delete();
    all_norm = 1;
    all_div0 = 1;
    for (int i = 0; i < N; i++) if (mask[i]) begin
      post(i);
      if (b_den[i] == '0) all_norm = 0;
      else                all_div0 = 0;
    end
    start = cyc;
    for (int j = 1; j <= N; j++) if (mask[(m_last + j) % N]) exp_order.push_back((m_last + j) % N);
    busy_seen = 0;
    k = 0;
    while (any_pend() && k < (N + 2) * LAT) begin
      step();
      busy_seen |= bus.BUSY;
      k++;
    end
    check("batch_done", 128'(any_pend()), 0);
    check("grant_count", 128'(q_grant.size()), 128'(exp_order.size()));
    for (int j = 0; j < exp_order.size() && j < q_grant.size(); j++)
      check("grant_order", 128'(q_grant[j]), 128'(exp_order[j]));
    check("first_ack_lat", 128'(ack_cyc[exp_order[0]] - start), 1);
    if (exp_order.size() == 1 && q_vcyc.size() == 1)
      check("valid_from_req", 128'(q_vcyc[0] - start), all_div0 ? 2 : LAT);
    if (all_norm) begin
      check("busy_seen", 128'(busy_seen), 1);
      for (int j = 1; j < q_vcyc.size(); j++) check("valid_spacing", 128'(q_vcyc[j] - q_vcyc[j-1]), LAT);
    end
    if (all_div0) check("busy_div0", 128'(busy_seen), 0);
    m_last = exp_order[exp_order.size() - 1];
  endtask

  task automatic single(input int ch, input logic [W-1:0] num, input logic [W-1:0] den);
    b_num[ch] = num;
    b_den[ch] = den;
    batch(N'(1) << ch);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ack"},   128'(bus.ACK),   0);
    check({tag, "_valid"}, 128'(bus.VALID), 0);
    check({tag, "_quo"},   128'(bus.QUO),   0);
    check({tag, "_rem"},   128'(bus.REM),   0);
    check({tag, "_div0"},  128'(bus.DIV0),  0);
    check({tag, "_busy"},  128'(bus.BUSY),  0);
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      m_quo[i]  = '0;
      m_rem[i]  = '0;
      m_div0[i] = 1'b0;
    end
    m_last = N - 1;
  endtask

  initial begin
    int k;
    logic [N-1:0] mask;
    bus.REQ = '0;
    bus.NUM = '0;
    bus.DEN = '0;
    clear_model();
    for (int i = 0; i < N; i++) begin
      pend[i]    = 1'b0;
      ack_cyc[i] = 0;
      p_div0[i]  = 1'b0;
      p_quo[i]   = '0;
      p_rem[i]   = '0;
    end

    repeat (2) step();
    check_zero("reset");
    RSTB = 1'b1;
    repeat (2) step();
    check_zero("idle");

    // single divide from the frequency example
    single(0, 32'd93284, 32'd100);
    check("quo0", 128'(bus.QUO[W-1:0]), 932);
    check("rem0", 128'(bus.REM[W-1:0]), 84);

    // round robin with all four, then 0 alone, then 1 and 3
    for (int i = 0; i < N; i++) begin
      b_num[i] = $urandom;
      b_den[i] = $urandom_range(1, 1000);
    end
    batch(4'b1111);
    single(0, 32'd7, 32'd2);
    b_num[1] = 32'd1000; b_den[1] = 32'd7;
    b_num[3] = 32'd55;   b_den[3] = 32'd9;
    batch(4'b1010);

    // divide by zero
    single(2, 32'h1234, 32'd0);
    check("div0_quo", 128'(bus.QUO[2*W +: W]), 128'hFFFF_FFFF);
    check("div0_flag", 128'(bus.DIV0[2]), 1);

    // width extremes
    single(0, 32'hFFFF_FFFF, 32'd1);
    single(1, 32'd5, 32'hFFFF_FFFF);
    single(3, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    check("ext_quo3", 128'(bus.QUO[3*W +: W]), 1);
    check("ext_rem3", 128'(bus.REM[3*W +: W]), 1);

    // reset in the middle of a channel 1 divide
    b_num[1] = 32'd123456; b_den[1] = 32'd77;
    post(1);
    repeat (10) step();
    RSTB = 1'b0;
    #1;
    check_zero("midreset");
    clear_model();
    post(1);
    repeat (3) step();
    RSTB = 1'b1;
    k = 0;
    while (pend[1] && k < 4 * LAT) begin
      step();
      k++;
    end
    check("midreset_done", 128'(pend[1]), 0);
    check("midreset_quo", 128'(bus.QUO[W +: W]), 128'(32'd123456 / 32'd77));
    m_last = 1;

    // hold and isolation: channel 3 result survives three channel 0 divides
    single(3, 32'd999, 32'd10);
    repeat (3) single(0, $urandom, $urandom_range(1, 65535));
    check("iso_quo3", 128'(bus.QUO[3*W +: W]), 99);

    // randomized mixes of channels and operand classes
    for (int it = 0; it < 25; it++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 7))
          0:       b_den[i] = '0;
          1:       b_den[i] = 32'd1;
          2:       b_den[i] = 32'hFFFF_FFFF;
          3:       b_den[i] = $urandom_range(1, 255);
          default: b_den[i] = $urandom;
        endcase
        b_num[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1000)) : 32'($urandom);
      end
      batch(mask);
    end

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
